// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_stream_loader
//  Purpose  : Loads a checksummed byte-stream image into the instruction
//             memory and holds the CPU in reset until a good image is loaded.
//  Revision : 1.0
// ============================================================================
module imem_stream_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_wa_o,
    output logic [31:0]   imem_wd_o,
    output logic          cpu_rst_o,
    output logic          done_o,
    output logic          error_o,
    output logic [AW:0]   words_loaded_o
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [7:0] c_max_words = 8'(DEPTH);
    localparam logic [AW:0] c_one      = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   asm_q, asm_d;
    logic [7:0]    sum_q, sum_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;
    logic [AW:0]   words_loaded_q, words_loaded_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          w_accept;
    logic [7:0]    w_sum_next;
    logic [31:0]   w_word;
    logic          w_last_word;

    assign in_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_sum_next = sum_q + in_data_i;
    // Only three bytes need storing: the fourth completes the word directly.
    assign w_word     = {asm_q, in_data_i};
    // words_loaded doubles as the word index of the word being assembled.
    assign w_last_word = (words_loaded_q == (count_q - c_one));

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        sum_d          = sum_q;
        we_d           = 1'b0;
        wa_d           = wa_q;
        wd_d           = wd_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_HDR: begin
                if (w_accept) begin
                    count_d    = in_data_i[AW:0];
                    byte_idx_d = 2'd0;
                    sum_d      = 8'd0;
                    // Full 8-bit compare so large headers cannot alias to legal counts.
                    if ((in_data_i == 8'd0) || (in_data_i > c_max_words)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    asm_d      = {asm_q[15:0], in_data_i};
                    sum_d      = w_sum_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d           = 1'b1;
                        wa_d           = words_loaded_q[AW-1:0];
                        wd_d           = w_word;
                        words_loaded_d = words_loaded_q + c_one;
                        if (w_last_word) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    state_d = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d        = S_HDR;
                    wa_d           = '0;
                    wd_d           = '0;
                    words_loaded_d = '0;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    // Status flags are registered from the next state so cpu_rst and done
    // change on the same edge and cpu_rst never glitches.
    always_comb begin
        done_d    = (state_d == S_DONE);
        error_d   = (state_d == S_ERR);
        cpu_rst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_HDR;
            count_q        <= '0;
            byte_idx_q     <= '0;
            asm_q          <= '0;
            sum_q          <= '0;
            we_q           <= 1'b0;
            wa_q           <= '0;
            wd_q           <= '0;
            words_loaded_q <= '0;
            cpu_rst_q      <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            sum_q          <= sum_d;
            we_q           <= we_d;
            wa_q           <= wa_d;
            wd_q           <= wd_d;
            words_loaded_q <= words_loaded_d;
            cpu_rst_q      <= cpu_rst_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign imem_we_o      = we_q;
    assign imem_wa_o      = wa_q;
    assign imem_wd_o      = wd_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_stream_loader
//  Purpose  : Scoreboard bench for imem_stream_loader.
//  Revision : 1.0
// ============================================================================
module tb_imem_stream_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_wa;
    logic [31:0]   imem_wd;
    logic          cpu_rst;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_stream_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (in_ready),
        .imem_we_o      (imem_we),
        .imem_wa_o      (imem_wa),
        .imem_wd_o      (imem_wd),
        .cpu_rst_o      (cpu_rst),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_e;
    logic [7:0]     sum_model;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Every write the DUT issues must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 32'(imem_wa), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("write_addr", 32'(imem_wa), 32'(mon_e[AW+31:32]));
                check_val("write_data", imem_wd, mon_e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (in_ready !== 1'b1 && k < 16) begin
            @(negedge clk);
            k++;
        end
        if (k == 16) check_val("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic stall3();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_stream(input logic [7:0] n);
        sum_model = 8'd0;
        send_byte(n);
    endtask

    task automatic send_word(input logic [31:0] w, input int wa, input bit gaps);
        logic [7:0] b;
        exp_q.push_back({AW'(wa), w});
        for (int i = 0; i < 4; i++) begin
            b = w[31-8*i -: 8];
            if (gaps && $urandom_range(0, 3) == 0) stall3();
            sum_model = sum_model + b;
            send_byte(b);
        end
    endtask

    task automatic finish_stream(input bit good);
        logic [7:0] c;
        c = 8'd0 - sum_model;
        if (!good) c = c - 8'd1;
        send_byte(c);
        drop_valid();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_restarted(input string tag);
        check_val({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_val({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_we", 32'(imem_we), 32'd0);
        check_val("rst_wa", 32'(imem_wa), 32'd0);
        check_val("rst_wd", imem_wd, 32'd0);
        check_val("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;

        // Nominal: data bytes sum to 0x438, so the correct checksum is 0xC8.
        start_stream(8'h02);
        send_word(32'h1234_5678, 0, 1'b0);
        send_word(32'h9ABC_DEF0, 1, 1'b0);
        finish_stream(1'b1);
        check_val("nom_done", 32'(done), 32'd1);
        check_val("nom_cpu_rst", 32'(cpu_rst), 32'd0);
        check_val("nom_error", 32'(error), 32'd0);
        check_val("nom_words", 32'(words_loaded), 32'd2);
        check_val("nom_in_ready", 32'(in_ready), 32'd0);
        check_val("nom_wa_held", 32'(imem_wa), 32'd1);
        check_val("nom_pending", 32'(exp_q.size()), 32'd0);

        pulse_start();
        check_restarted("restart_done");

        // Checksum off by one.
        start_stream(8'h02);
        send_word(32'h1234_5678, 0, 1'b0);
        send_word(32'h9ABC_DEF0, 1, 1'b0);
        finish_stream(1'b0);
        check_val("csum_error", 32'(error), 32'd1);
        check_val("csum_done", 32'(done), 32'd0);
        check_val("csum_cpu_rst", 32'(cpu_rst), 32'd1);
        check_val("csum_in_ready", 32'(in_ready), 32'd0);
        check_val("csum_words", 32'(words_loaded), 32'd2);
        pulse_start();
        check_restarted("restart_err");

        // Bad headers: zero words and one more than the memory holds.
        start_stream(8'h00);
        drop_valid();
        check_val("hdr0_error", 32'(error), 32'd1);
        check_val("hdr0_in_ready", 32'(in_ready), 32'd0);
        check_val("hdr0_cpu_rst", 32'(cpu_rst), 32'd1);
        repeat (2) @(negedge clk);
        pulse_start();
        start_stream(8'h41);
        drop_valid();
        check_val("hdr65_error", 32'(error), 32'd1);
        check_val("hdr65_in_ready", 32'(in_ready), 32'd0);
        check_val("hdr65_words", 32'(words_loaded), 32'd0);
        repeat (2) @(negedge clk);
        pulse_start();

        // Full depth with random 3-cycle stalls and an ignored start in DATA.
        start_stream(8'h40);
        for (int k = 0; k < DEPTH; k++) begin
            send_word(32'(k), k, 1'b1);
            if (k == 10) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start    = 1'b0;
                check_val("start_in_data_ready", 32'(in_ready), 32'd1);
                check_val("start_in_data_words", 32'(words_loaded), 32'd11);
            end
        end
        finish_stream(1'b1);
        check_val("full_done", 32'(done), 32'd1);
        check_val("full_words", 32'(words_loaded), 32'd64);
        check_val("full_cpu_rst", 32'(cpu_rst), 32'd0);
        check_val("full_pending", 32'(exp_q.size()), 32'd0);
        pulse_start();

        // Asynchronous reset after word 1 of a 4-word image.
        start_stream(8'h04);
        send_word(32'hA1A2_A3A4, 0, 1'b0);
        send_word(32'hB1B2_B3B4, 1, 1'b0);
        drop_valid();
        #2 rst = 1'b1;
        #1;
        check_val("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_val("midrst_words", 32'(words_loaded), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        start_stream(8'h01);
        send_word(32'hCAFE_F00D, 0, 1'b0);
        finish_stream(1'b1);
        check_val("fresh_done", 32'(done), 32'd1);
        check_val("fresh_words", 32'(words_loaded), 32'd1);
        check_val("fresh_cpu_rst", 32'(cpu_rst), 32'd0);

        repeat (2) @(negedge clk);
        check_val("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
